// File: rtl/life_gen_step_if.sv
// Bus between the Life generation engine and its board RAM / controlling FSM.
// The engine uses the master view; the RAM and controller side use slave.
interface life_gen_step_if #(
  parameter int COLS = 40,
  parameter int AW   = 5
);
  logic            start;
  logic            busy;
  logic            done;
  logic [AW-1:0]   rd_addr;
  logic [COLS-1:0] rd_data;
  logic [AW-1:0]   wr_addr;
  logic [COLS-1:0] wr_data;
  logic            wren;
  logic [10:0]     live_count;
  logic            changed;

  modport master (
    input  start, rd_data,
    output busy, done, rd_addr, wr_addr, wr_data, wren, live_count, changed
  );

  modport slave (
    output start, rd_data,
    input  busy, done, rd_addr, wr_addr, wr_data, wren, live_count, changed
  );
endinterface

// File: rtl/life_gen_step.sv
// One Life generation over the board RAM: rows stream through a 3-row window
// (above / cur / incoming) and each next-generation row is written back in place.
module life_gen_step #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  life_gen_step_if.master bus
);
  localparam int PW = $clog2(COLS + 1);

  typedef enum logic [2:0] {IDLE, FILL, LOAD0, ROW, DONE} state_t;

  state_t          state_reg;
  logic [COLS-1:0] above_reg;
  logic [COLS-1:0] cur_reg;
  logic [AW-1:0]   r_reg;
  logic [10:0]     live_count_reg;
  logic            changed_reg;

  logic            last_row;
  logic [COLS-1:0] inc_row;
  logic [AW:0]     r_plus2;
  logic [AW-1:0]   row_rd_addr;
  logic [AW-1:0]   rd_addr_next;
  logic [COLS-1:0] next_row;
  logic [PW-1:0]   row_pop;

  assign last_row = (r_reg == AW'(ROWS - 1));
  // Below the last row the board is dead, whatever the RAM returns.
  assign inc_row  = last_row ? '0 : bus.rd_data;

  assign r_plus2     = {1'b0, r_reg} + (AW + 1)'(2);
  assign row_rd_addr = (r_plus2 < (AW + 1)'(ROWS)) ? r_plus2[AW-1:0] : '0;

  // One zero cell of padding on each side keeps column 0 and COLS-1 from wrapping.
  logic [COLS+1:0] a_pad;
  logic [COLS+1:0] c_pad;
  logic [COLS+1:0] b_pad;

  assign a_pad = {1'b0, above_reg, 1'b0};
  assign c_pad = {1'b0, cur_reg,   1'b0};
  assign b_pad = {1'b0, inc_row,   1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_cell
      logic [3:0] n;
      assign n = {3'b0, a_pad[gi]} + {3'b0, a_pad[gi+1]} + {3'b0, a_pad[gi+2]}
               + {3'b0, c_pad[gi]}                       + {3'b0, c_pad[gi+2]}
               + {3'b0, b_pad[gi]} + {3'b0, b_pad[gi+1]} + {3'b0, b_pad[gi+2]};
      assign next_row[gi] = (n == 4'd3) | (cur_reg[gi] & (n == 4'd2));
    end
  endgenerate

  always_comb begin
    row_pop = '0;
    for (int i = 0; i < COLS; i++) begin
      row_pop = row_pop + {{(PW-1){1'b0}}, next_row[i]};
    end
  end

  always_comb begin
    rd_addr_next = '0;
    case (state_reg)
      LOAD0:   rd_addr_next = AW'(1);
      ROW:     rd_addr_next = row_rd_addr;
      default: rd_addr_next = '0;
    endcase
  end

  assign bus.rd_addr    = rd_addr_next;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.done       = (state_reg == DONE);
  assign bus.wren       = (state_reg == ROW);
  assign bus.wr_addr    = (state_reg == ROW) ? r_reg : '0;
  assign bus.wr_data    = (state_reg == ROW) ? next_row : '0;
  assign bus.live_count = live_count_reg;
  assign bus.changed    = changed_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      above_reg      <= '0;
      cur_reg        <= '0;
      r_reg          <= '0;
      live_count_reg <= '0;
      changed_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg      <= FILL;
            live_count_reg <= '0;
            changed_reg    <= 1'b0;
          end
        end
        FILL: begin
          above_reg <= '0;
          cur_reg   <= '0;
          r_reg     <= '0;
          state_reg <= LOAD0;
        end
        LOAD0: begin
          cur_reg   <= bus.rd_data;
          state_reg <= ROW;
        end
        ROW: begin
          // Row r is committed this cycle; slide the window down one row.
          above_reg      <= cur_reg;
          cur_reg        <= inc_row;
          live_count_reg <= live_count_reg + 11'(row_pop);
          changed_reg    <= changed_reg | (next_row != cur_reg);
          if (last_row) begin
            state_reg <= DONE;
          end else begin
            r_reg <= r_reg + AW'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end
endmodule
